// File: rtl/cajero_pkg.sv
// Shared types and defaults for the ATM (cajero) balance datapath.
// One-hot state encoding and transaction-type codes live here.
package cajero_pkg;

    localparam int ANCHO_DEF         = 32;
    localparam int LIMITE_RETIRO_DEF = 500000;

    localparam logic TRANS_DEPOSITO = 1'b0;
    localparam logic TRANS_RETIRO   = 1'b1;

    localparam logic [5:0] ST_IDLE         = 6'b000001;
    localparam logic [5:0] ST_ESPERA_MONTO = 6'b000010;
    localparam logic [5:0] ST_VERIFICAR    = 6'b000100;
    localparam logic [5:0] ST_ACTUALIZAR   = 6'b001000;
    localparam logic [5:0] ST_ENTREGAR     = 6'b010000;
    localparam logic [5:0] ST_FIN          = 6'b100000;

    typedef enum logic [5:0] {
        IDLE         = ST_IDLE,
        ESPERA_MONTO = ST_ESPERA_MONTO,
        VERIFICAR    = ST_VERIFICAR,
        ACTUALIZAR   = ST_ACTUALIZAR,
        ENTREGAR     = ST_ENTREGAR,
        FIN          = ST_FIN
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controlador_transaccion_if.sv
// Request/response bundle between the PIN FSM side and the
// transaction controller.
interface controlador_transaccion_if #(
    parameter int ANCHO = cajero_pkg::ANCHO_DEF
);
    logic             inicio;
    logic             tipo_trans;
    logic [ANCHO-1:0] balance_inicial;
    logic             monto_stb;
    logic [ANCHO-1:0] monto;
    logic             cancelar;
    logic             nuevo_dia;

    logic [ANCHO-1:0] balance_actualizado;
    logic             entregar_dinero;
    logic             fondos_insuficientes;
    logic             limite_excedido;
    logic             desborde;
    logic             tiempo_agotado;
    logic             ocupado;
    logic             transaccion_fin;

    modport master (
        output inicio, tipo_trans, balance_inicial,
        output monto_stb, monto, cancelar, nuevo_dia,
        input  balance_actualizado, entregar_dinero,
        input  fondos_insuficientes, limite_excedido,
        input  desborde, tiempo_agotado,
        input  ocupado, transaccion_fin
    );

    modport slave (
        input  inicio, tipo_trans, balance_inicial,
        input  monto_stb, monto, cancelar, nuevo_dia,
        output balance_actualizado, entregar_dinero,
        output fondos_insuficientes, limite_excedido,
        output desborde, tiempo_agotado,
        output ocupado, transaccion_fin
    );
endinterface

// File: rtl/contador_ciclos.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared between the amount timeout and the dispense window.
module contador_ciclos
    import cajero_pkg::*;
#(
    parameter int ANCHO_CNT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cargar,
    input  logic                 decrementar,
    input  logic [ANCHO_CNT-1:0] valor,
    output logic                 cero
);

    logic [ANCHO_CNT-1:0] cuenta;

    always_ff @(posedge clock) begin
        if (reset) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor;
        end else if (decrementar && (cuenta != '0)) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/controlador_transaccion.sv
// ATM transaction sequencer: amount wait, funds/limit/overflow check,
// balance update and timed cash dispense with sticky error flags.
module controlador_transaccion
    import cajero_pkg::*;
#(
    parameter int ANCHO          = ANCHO_DEF,
    parameter int LIMITE_RETIRO  = LIMITE_RETIRO_DEF,
    parameter int ENTREGA_CICLOS = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic                       clock,
    input logic                       reset,
    controlador_transaccion_if.slave  bus
);

    localparam int CNT_W =
        $clog2(max_int(TIMEOUT_CICLOS, ENTREGA_CICLOS) + 1);
    // Loading N-1 and leaving on zero keeps the phase exactly N cycles.
    localparam logic [CNT_W-1:0] CARGA_ESPERA  = CNT_W'(TIMEOUT_CICLOS - 1);
    localparam logic [CNT_W-1:0] CARGA_ENTREGA = CNT_W'(ENTREGA_CICLOS - 1);
    localparam logic [ANCHO:0]   LIMITE        = (ANCHO+1)'(LIMITE_RETIRO);

    estado_t          estado;
    logic             tipo;
    logic [ANCHO-1:0] balance;
    logic [ANCHO-1:0] monto_reg;
    logic [ANCHO-1:0] retirado_acum;
    logic             fondos;
    logic             limite;
    logic             desborde;
    logic             tiempo;

    logic             cargar;
    logic             decrementar;
    logic [CNT_W-1:0] valor;
    logic             cero;

    logic [ANCHO:0]   suma_dep;
    logic [ANCHO:0]   suma_lim;

    assign suma_dep = {1'b0, balance} + {1'b0, monto_reg};
    assign suma_lim = {1'b0, retirado_acum} + {1'b0, monto_reg};

    always_comb begin
        cargar      = 1'b0;
        decrementar = 1'b0;
        valor       = '0;
        case (estado)
            IDLE: begin
                cargar = bus.inicio;
                valor  = CARGA_ESPERA;
            end
            ESPERA_MONTO: decrementar = 1'b1;
            ACTUALIZAR: begin
                cargar = (tipo == TRANS_RETIRO);
                valor  = CARGA_ENTREGA;
            end
            ENTREGAR: decrementar = 1'b1;
            default: ;
        endcase
    end

    contador_ciclos #(
        .ANCHO_CNT (CNT_W)
    ) u_contador (
        .clock       (clock),
        .reset       (reset),
        .cargar      (cargar),
        .decrementar (decrementar),
        .valor       (valor),
        .cero        (cero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= IDLE;
            tipo          <= TRANS_DEPOSITO;
            balance       <= '0;
            monto_reg     <= '0;
            retirado_acum <= '0;
            fondos        <= 1'b0;
            limite        <= 1'b0;
            desborde      <= 1'b0;
            tiempo        <= 1'b0;
        end else begin
            if (bus.nuevo_dia) begin
                retirado_acum <= '0;
            end
            case (estado)
                IDLE: begin
                    if (bus.inicio) begin
                        balance  <= bus.balance_inicial;
                        tipo     <= bus.tipo_trans;
                        fondos   <= 1'b0;
                        limite   <= 1'b0;
                        desborde <= 1'b0;
                        tiempo   <= 1'b0;
                        estado   <= ESPERA_MONTO;
                    end
                end
                ESPERA_MONTO: begin
                    if (bus.cancelar) begin
                        estado <= FIN;
                    end else if (bus.monto_stb) begin
                        monto_reg <= bus.monto;
                        estado    <= VERIFICAR;
                    end else if (cero) begin
                        tiempo <= 1'b1;
                        estado <= FIN;
                    end
                end
                VERIFICAR: begin
                    if (tipo == TRANS_DEPOSITO) begin
                        if (suma_dep[ANCHO]) begin
                            desborde <= 1'b1;
                            estado   <= FIN;
                        end else begin
                            estado <= ACTUALIZAR;
                        end
                    end else if (monto_reg > balance) begin
                        fondos <= 1'b1;
                        estado <= FIN;
                    end else if (suma_lim > LIMITE) begin
                        limite <= 1'b1;
                        estado <= FIN;
                    end else begin
                        estado <= ACTUALIZAR;
                    end
                end
                ACTUALIZAR: begin
                    if (tipo == TRANS_DEPOSITO) begin
                        balance <= suma_dep[ANCHO-1:0];
                        estado  <= FIN;
                    end else begin
                        balance <= balance - monto_reg;
                        // Same-cycle day rollover clears before accumulating.
                        retirado_acum <= (bus.nuevo_dia ? '0 : retirado_acum)
                                         + monto_reg;
                        estado <= ENTREGAR;
                    end
                end
                ENTREGAR: begin
                    if (cero) begin
                        estado <= FIN;
                    end
                end
                FIN: estado <= IDLE;
                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.balance_actualizado  = balance;
    assign bus.entregar_dinero      = (estado == ENTREGAR);
    assign bus.fondos_insuficientes = fondos;
    assign bus.limite_excedido      = limite;
    assign bus.desborde             = desborde;
    assign bus.tiempo_agotado       = tiempo;
    assign bus.ocupado              = (estado != IDLE);
    assign bus.transaccion_fin      = (estado == FIN);

endmodule
